// File: rtl/addsub_flags_unit_if.sv
// rtl/addsub_flags_unit_if.sv - request/result handshake bundle for the add/subtract flags unit
interface addsub_flags_unit_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         set_flags;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   out_flags;
  logic         out_wr;
  logic         out_err;
  logic [3:0]   flags;

  modport master (
    output in_valid, op, set_flags, a, b, out_ready,
    input  in_ready, out_valid, result, out_flags, out_wr, out_err, flags
  );

  modport slave (
    input  in_valid, op, set_flags, a, b, out_ready,
    output in_ready, out_valid, result, out_flags, out_wr, out_err, flags
  );
endinterface

// File: rtl/addsub_flags_unit.sv
// rtl/addsub_flags_unit.sv - registered add/subtract unit with persistent ZNCV flags
module addsub_flags_unit #(
  parameter int       N          = 32,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_flags_unit_if.slave   bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_RSB = 3'b010;
  localparam logic [2:0] OP_ADC = 3'b011;
  localparam logic [2:0] OP_SBC = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  logic         valid_q;
  logic [N-1:0] result_q;
  logic [3:0]   oflags_q;
  logic         wr_q;
  logic         err_q;
  logic [3:0]   flags_q;

  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         cin;
  logic [N:0]   sum;
  logic         reserved;
  logic         is_cmp;
  logic [3:0]   new_flags;
  logic         accept;

  // Every op is x + y + cin with the operands pre-inverted for subtract forms.
  always_comb begin
    x        = bus.a;
    y        = ~bus.b;
    cin      = 1'b1;
    reserved = 1'b0;
    is_cmp   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        y   = bus.b;
        cin = 1'b0;
      end
      OP_SUB: ;
      OP_CMP: is_cmp = 1'b1;
      OP_RSB: begin
        x = bus.b;
        y = ~bus.a;
      end
      OP_ADC: begin
        y   = bus.b;
        cin = flags_q[1];
      end
      OP_SBC: cin = flags_q[1];
      default: reserved = 1'b1;
    endcase
    sum       = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
    new_flags = {sum[N-1:0] == '0, sum[N-1], sum[N],
                 (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1])};
    if (reserved) begin
      new_flags = 4'b0000;
    end
  end

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.out_flags = oflags_q;
  assign bus.out_wr    = wr_q;
  assign bus.out_err   = err_q;
  assign bus.flags     = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      oflags_q <= 4'b0000;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      flags_q  <= FLAG_RESET;
    end else begin
      if (accept) begin
        valid_q  <= 1'b1;
        result_q <= reserved ? '0 : sum[N-1:0];
        oflags_q <= new_flags;
        wr_q     <= !reserved && !is_cmp;
        err_q    <= reserved;
        // Compares exist only to set flags, so they ignore set_flags.
        if (!reserved && (bus.set_flags || is_cmp)) begin
          flags_q <= new_flags;
        end
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end
endmodule
